// File: rtl/hex_display_ctrl_if.sv
// Display-update write channel: one requester pushes a six-digit hex value
// plus leading-zero and per-digit blink attributes over valid/ready.
interface hex_display_ctrl_if;
  logic        valid;
  logic        ready;
  logic [23:0] value;
  logic        lz;
  logic [5:0]  blink;

  modport master (output valid, output value, output lz, output blink, input ready);
  modport slave  (input valid, input value, input lz, input blink, output ready);
endinterface

// File: rtl/hex_display_ctrl.sv
// Six-digit 7-segment controller for HEX0..HEX5. Two requesters (A = host,
// B = debug) are arbitrated round-robin; the granted update is latched and
// the displays are driven from registers with leading-zero blanking and
// per-digit blinking. Segments are active-low, bit 6 = g ... bit 0 = a.
module hex_display_ctrl #(
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hex_display_ctrl_if.slave     a,
  hex_display_ctrl_if.slave     b,
  output logic [6:0]            hex0,
  output logic [6:0]            hex1,
  output logic [6:0]            hex2,
  output logic [6:0]            hex3,
  output logic [6:0]            hex4,
  output logic [6:0]            hex5,
  output logic                  grant_b
);

  localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_UPDATE = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last_b;
  logic                w_grant_b;
  logic                w_a_ready;
  logic                w_b_ready;
  logic                w_xfer;

  logic [23:0]         r_value;
  logic                r_lz;
  logic [5:0]          r_blink;
  logic                r_src_b;
  logic                r_grant_b;

  logic [CNT_W-1:0]    r_cnt;
  logic                r_phase;
  logic                w_wrap;

  logic [5:0]          w_lz_blank;
  logic [5:0][6:0]     w_hex_nxt;
  logic [5:0][6:0]     r_hex;

  // Hex nibble to active-low segment pattern (bit 6 = g ... bit 0 = a).
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1011000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b0100111;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // Round-robin pick: on contention favour whoever was not granted last.
  always_comb begin
    w_grant_b = b.valid;
    if (a.valid && b.valid) begin
      w_grant_b = ~r_last_b;
    end
  end

  // Next-state and ready generation; ready is held low while in reset.
  always_comb begin
    w_state_nxt = r_state;
    w_a_ready   = 1'b0;
    w_b_ready   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_a_ready = rst_n & a.valid & ~w_grant_b;
        w_b_ready = rst_n & b.valid &  w_grant_b;
        if (w_a_ready || w_b_ready) begin
          w_state_nxt = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_xfer  = w_a_ready | w_b_ready;
  assign a.ready = w_a_ready;
  assign b.ready = w_b_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latch the granted payload and remember who won for round-robin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value  <= 24'd0;
      r_lz     <= 1'b0;
      r_blink  <= 6'd0;
      r_src_b  <= 1'b0;
      r_last_b <= 1'b1;
    end else if (w_xfer) begin
      r_src_b  <= w_grant_b;
      r_last_b <= w_grant_b;
      if (w_grant_b) begin
        r_value <= b.value;
        r_lz    <= b.lz;
        r_blink <= b.blink;
      end else begin
        r_value <= a.value;
        r_lz    <= a.lz;
        r_blink <= a.blink;
      end
    end
  end

  assign w_wrap = (r_cnt == CNT_LAST);

  // Free-running blink timebase, independent of writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (w_wrap) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  // Per-digit blank/decode; digit k is LZ-blanked when nibbles k..5 are zero.
  always_comb begin
    w_lz_blank = '0;
    w_hex_nxt  = '0;
    for (int k = 1; k < 6; k++) begin
      w_lz_blank[k] = r_lz;
      for (int j = k; j < 6; j++) begin
        if (r_value[4*j +: 4] != 4'd0) begin
          w_lz_blank[k] = 1'b0;
        end
      end
    end
    for (int k = 0; k < 6; k++) begin
      if (w_lz_blank[k] || (r_phase && r_blink[k])) begin
        w_hex_nxt[k] = 7'h7F;
      end else begin
        w_hex_nxt[k] = seg_decode(r_value[4*k +: 4]);
      end
    end
  end

  // Registered segment drive and source indicator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hex     <= {6{7'h7F}};
      r_grant_b <= 1'b0;
    end else begin
      r_hex     <= w_hex_nxt;
      r_grant_b <= r_src_b;
    end
  end

  assign hex0    = r_hex[0];
  assign hex1    = r_hex[1];
  assign hex2    = r_hex[2];
  assign hex3    = r_hex[3];
  assign hex4    = r_hex[4];
  assign hex5    = r_hex[5];
  assign grant_b = r_grant_b;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl: randomized and directed writes from two
// requesters, checked every cycle against a transaction-level model.
module tb_hex_display_ctrl;

  localparam int BDIV = 4;

  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hex_display_ctrl_if a_if ();
  hex_display_ctrl_if b_if ();

  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic       grant_b;

  hex_display_ctrl #(.BLINK_DIV(BDIV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a_if),
    .b       (b_if),
    .hex0    (hex0),
    .hex1    (hex1),
    .hex2    (hex2),
    .hex3    (hex3),
    .hex4    (hex4),
    .hex5    (hex5),
    .grant_b (grant_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // ecnt: clock edges since reset release. m_xedge: edge of the latest write.
  // "new" is the latest accepted write, "old" the one before it; the display
  // shows a write only once an edge after its acceptance edge has passed.
  int          ecnt;
  int          m_xedge;
  logic [23:0] m_new_v, m_old_v;
  logic        m_new_lz, m_old_lz;
  logic [5:0]  m_new_bl, m_old_bl;
  logic        m_new_src, m_old_src;
  logic        m_last_b;

  function automatic bit pick_b(input bit av, input bit bv, input bit last_b);
    if (av && bv) return !last_b;
    return bv;
  endfunction

  function automatic logic [6:0] exp_digit(input int k, input logic [23:0] v,
                                           input logic lz, input logic [5:0] bl, input bit ph);
    logic [23:0] upper;
    upper = v >> (4 * k);
    if (lz && k > 0 && upper == 24'd0) return 7'h7F;
    if (ph && bl[k]) return 7'h7F;
    return SEG[upper[3:0]];
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    if (!rst_n) begin
      ecnt      <= 0;
      m_xedge   <= -10;
      m_new_v   <= '0; m_old_v   <= '0;
      m_new_lz  <= 1'b0; m_old_lz <= 1'b0;
      m_new_bl  <= '0; m_old_bl  <= '0;
      m_new_src <= 1'b0; m_old_src <= 1'b0;
      m_last_b  <= 1'b1;
    end else begin
      ecnt <= ecnt + 1;
      if ((m_xedge != ecnt) && (a_if.valid || b_if.valid)) begin
        m_old_v   <= m_new_v;
        m_old_lz  <= m_new_lz;
        m_old_bl  <= m_new_bl;
        m_old_src <= m_new_src;
        m_xedge   <= ecnt + 1;
        m_last_b  <= pick_b(a_if.valid, b_if.valid, m_last_b);
        if (pick_b(a_if.valid, b_if.valid, m_last_b)) begin
          m_new_v <= b_if.value; m_new_lz <= b_if.lz; m_new_bl <= b_if.blink; m_new_src <= 1'b1;
        end else begin
          m_new_v <= a_if.value; m_new_lz <= a_if.lz; m_new_bl <= a_if.blink; m_new_src <= 1'b0;
        end
      end
    end
  end

  task automatic check_outputs();
    logic [6:0]  dh [6];
    logic [23:0] sv;
    logic        slz, ssrc;
    logic [5:0]  sbl;
    bit          busy, gb, ph;
    dh[0] = hex0; dh[1] = hex1; dh[2] = hex2;
    dh[3] = hex3; dh[4] = hex4; dh[5] = hex5;
    if (!rst_n) begin
      for (int k = 0; k < 6; k++) chk($sformatf("hex%0d_in_reset", k), dh[k], 7'h7F);
      chk("grant_b_in_reset", grant_b, 1'b0);
      chk("a_ready_in_reset", a_if.ready, 1'b0);
      chk("b_ready_in_reset", b_if.ready, 1'b0);
      return;
    end
    busy = (m_xedge == ecnt);
    gb   = pick_b(a_if.valid, b_if.valid, m_last_b);
    chk("a_ready", a_if.ready, !busy && a_if.valid && !gb);
    chk("b_ready", b_if.ready, !busy && b_if.valid && gb);
    if (ecnt == 0) begin
      for (int k = 0; k < 6; k++) chk($sformatf("hex%0d_after_release", k), dh[k], 7'h7F);
      chk("grant_b_after_release", grant_b, 1'b0);
    end else begin
      if (m_xedge == ecnt) begin
        sv = m_old_v; slz = m_old_lz; sbl = m_old_bl; ssrc = m_old_src;
      end else begin
        sv = m_new_v; slz = m_new_lz; sbl = m_new_bl; ssrc = m_new_src;
      end
      ph = (((ecnt - 1) / BDIV) % 2) == 1;
      for (int k = 0; k < 6; k++) chk($sformatf("hex%0d", k), dh[k], exp_digit(k, sv, slz, sbl, ph));
      chk("grant_b", grant_b, ssrc);
    end
  endtask

  always @(negedge clk) check_outputs();

  // ---------------- stimulus ----------------
  task automatic wr(input bit src, input logic [23:0] v, input logic lz, input logic [5:0] bl);
    int  n;
    bit  rdy;
    @(posedge clk); #1;
    if (src) begin
      b_if.valid = 1'b1; b_if.value = v; b_if.lz = lz; b_if.blink = bl;
    end else begin
      a_if.valid = 1'b1; a_if.value = v; a_if.lz = lz; a_if.blink = bl;
    end
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 20) begin
      @(negedge clk);
      rdy = src ? b_if.ready : a_if.ready;
      n++;
    end
    chk("wr_ready_seen", rdy, 1'b1);
    @(posedge clk); #1;
    if (src) b_if.valid = 1'b0;
    else     a_if.valid = 1'b0;
  endtask

  task automatic settle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin : main
    bit          a_acc, b_acc;
    int          off_cnt, per_err;
    logic [6:0]  h0 [16];
    logic [1:0]  exp_rdy;
    a_if.valid = 1'b0; a_if.value = '0; a_if.lz = 1'b0; a_if.blink = '0;
    b_if.valid = 1'b0; b_if.value = '0; b_if.lz = 1'b0; b_if.blink = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("lit_rst_hex0", hex0, 7'h7F);
    chk("lit_rst_grant", grant_b, 1'b0);
    @(negedge clk); #1 rst_n = 1'b1;
    #1;
    chk("lit_rel_hex5", hex5, 7'h7F);

    // single write
    wr(1'b0, 24'h123456, 1'b0, 6'd0);
    settle();
    chk("lit_123456_hex5", hex5, 7'b1111001);
    chk("lit_123456_hex4", hex4, 7'b0100100);
    chk("lit_123456_hex3", hex3, 7'b0110000);
    chk("lit_123456_hex2", hex2, 7'b0011001);
    chk("lit_123456_hex1", hex1, 7'b0010010);
    chk("lit_123456_hex0", hex0, 7'b0000010);

    // leading-zero blanking
    wr(1'b0, 24'h00000A, 1'b1, 6'd0);
    settle();
    chk("lit_lzA_hex5", hex5, 7'h7F);
    chk("lit_lzA_hex1", hex1, 7'h7F);
    chk("lit_lzA_hex0", hex0, 7'b0001000);
    wr(1'b0, 24'h000000, 1'b1, 6'd0);
    settle();
    chk("lit_lz0_hex1", hex1, 7'h7F);
    chk("lit_lz0_hex0", hex0, 7'b1000000);
    wr(1'b0, 24'h050000, 1'b1, 6'd0);
    settle();
    chk("lit_lz5_hex5", hex5, 7'h7F);
    chk("lit_lz5_hex4", hex4, 7'b0010010);
    chk("lit_lz5_hex3", hex3, 7'b1000000);
    chk("lit_lz5_hex0", hex0, 7'b1000000);

    // contention round-robin (B written last, so A wins first)
    wr(1'b1, 24'h0000BB, 1'b0, 6'd0);
    settle();
    chk("lit_b_grant", grant_b, 1'b1);
    @(posedge clk); #1;
    a_if.value = 24'hAAAAAA; a_if.lz = 1'b0; a_if.blink = '0; a_if.valid = 1'b1;
    b_if.value = 24'hBBBBBB; b_if.lz = 1'b0; b_if.blink = '0; b_if.valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_rdy = (i % 4 == 0) ? 2'b10 : (i % 4 == 2) ? 2'b01 : 2'b00;
      chk($sformatf("lit_rr_cycle%0d", i), {a_if.ready, b_if.ready}, exp_rdy);
    end
    @(posedge clk); #1;
    a_if.valid = 1'b0; b_if.valid = 1'b0;

    // blink on HEX0 only
    wr(1'b0, 24'hFFFFFF, 1'b0, 6'b000001);
    settle();
    off_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      h0[i] = hex0;
      if (hex0 == 7'h7F) off_cnt++;
      chk("lit_blink_hex1_steady", hex1, 7'b0001110);
    end
    per_err = 0;
    for (int i = 0; i < 12; i++) if (h0[i] == h0[i+4]) per_err++;
    chk("lit_blink_off_count", off_cnt, 8);
    chk("lit_blink_period", per_err, 0);

    // B raised during UPDATE is served in the following IDLE cycle
    wr(1'b0, 24'h111111, 1'b0, 6'd0);
    b_if.value = 24'h222222; b_if.lz = 1'b0; b_if.blink = '0; b_if.valid = 1'b1;
    @(negedge clk);
    chk("lit_b_ready_in_update", b_if.ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lit_b_ready_next_idle", b_if.ready, 1'b1);
    @(posedge clk); #1 b_if.valid = 1'b0;
    settle();
    chk("lit_b_served_hex0", hex0, 7'b0100100);
    chk("lit_b_served_grant", grant_b, 1'b1);

    // A raised and withdrawn before ready: nothing latched
    wr(1'b1, 24'h333333, 1'b0, 6'd0);
    a_if.value = 24'h999999; a_if.valid = 1'b1;
    #2 chk("lit_withdraw_no_ready", a_if.ready, 1'b0);
    @(negedge clk); #1 a_if.valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("lit_withdraw_hex5", hex5, 7'b0110000);
    chk("lit_withdraw_grant", grant_b, 1'b1);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      a_acc = a_if.ready;
      b_acc = b_if.ready;
      @(posedge clk); #1;
      if (a_if.valid && !a_acc) begin
        if ($urandom_range(0, 7) == 0) a_if.valid = 1'b0;
      end else begin
        a_if.valid = $urandom_range(0, 1);
        a_if.value = 24'($urandom >> (4 * $urandom_range(0, 6)));
        a_if.lz    = $urandom_range(0, 1);
        a_if.blink = 6'($urandom);
      end
      if (b_if.valid && !b_acc) begin
        if ($urandom_range(0, 7) == 0) b_if.valid = 1'b0;
      end else begin
        b_if.valid = $urandom_range(0, 1);
        b_if.value = 24'($urandom >> (4 * $urandom_range(0, 6)));
        b_if.lz    = $urandom_range(0, 1);
        b_if.blink = 6'($urandom);
      end
    end
    @(posedge clk); #1;
    a_if.valid = 1'b0; b_if.valid = 1'b0;
    repeat (2) @(negedge clk);

    // async reset during UPDATE with A pending
    wr(1'b0, 24'h654321, 1'b0, 6'd0);
    settle();
    wr(1'b1, 24'h0000C0, 1'b0, 6'd0);
    a_if.value = 24'h777777; a_if.lz = 1'b0; a_if.blink = '0; a_if.valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("lit_async_hex0", hex0, 7'h7F);
    chk("lit_async_hex3", hex3, 7'h7F);
    chk("lit_async_hex5", hex5, 7'h7F);
    chk("lit_async_a_ready", a_if.ready, 1'b0);
    a_if.valid = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
    #1 chk("lit_post_rst_hex2", hex2, 7'h7F);
    @(posedge clk); #1;
    a_if.valid = 1'b1; b_if.valid = 1'b1; b_if.value = 24'h0000EE;
    @(negedge clk);
    chk("lit_post_rst_grant_a", {a_if.ready, b_if.ready}, 2'b10);
    @(posedge clk); #1;
    a_if.valid = 1'b0; b_if.valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex_display_ctrl.md
# hex_display_ctrl

Six-digit 7-segment display controller for the DE10-Lite HEX0–HEX5 displays. It arbitrates display-update writes from two requesters, a primary host (A) and a debug source (B), using round-robin with a valid/ready handshake. It latches the granted value and per-digit attributes, and drives registered, active-low segment patterns with optional leading-zero blanking and per-digit blinking. It sits between user logic and the board's HEX pins.

## Interface
- `BLINK_DIV`, default 12_500_000: clock cycles per blink half-period, so 2 Hz blink at 50 MHz. Legal range is ≥2.
- `clk` in 1: system clock, 50 MHz board clock.
- `rst_n` in 1: reset. **One clock; reset is asynchronous and active-low.**
- `a_valid` in 1: requester A has an update pending.
- `a_ready` out 1: requester A's update is accepted this cycle.
- `a_value` in 24: six hex nibbles. [3:0] goes to HEX0; [23:20] goes to HEX5.
- `a_lz` in 1: leading-zero blanking enable.
- `a_blink` in 6: per-digit blink mask. Bit k controls HEXk.
- `b_valid`, `b_ready`, `b_value`, `b_lz`, `b_blink`: same as the A signals, for requester B.
- `hex0` … `hex5` out 7 each: segment drive, active-low. Bit 6 = g … bit 0 = a.
- `grant_b` out 1: source of the currently displayed value (0 = A, 1 = B).

## Operation
- FSM states:
  - IDLE: accepts at most one write.
  - UPDATE: one cycle; no accept; always returns to IDLE.
- Arbitration happens in IDLE only.
  - Only one requester valid: grant it.
  - Both valid: grant the one not granted last. `last_b` resets to 1, so A wins the first contention.
- Handshake:
  - `x_ready` = state==IDLE && `x_valid` && granted. It is combinational from valid and is never asserted for both requesters.
  - Transfer occurs when `x_valid && x_ready`.
  - Requesters must hold valid and payload stable until ready.
  - Dropping valid before transfer is legal; nothing is latched.
- On transfer:
  - Load `value_q`, `lz_q`, `blink_q` and `grant_b` from the granted requester.
  - Update `last_b`.
  - Go to UPDATE.
  - Maximum write rate is one every 2 cycles.
- Decode table, input nibble → 7-bit pattern:
  - 0→1000000, 1→1111001, 2→0100100, 3→0110000
  - 4→0011001, 5→0010010, 6→0000010, 7→1011000
  - 8→0000000, 9→0010000, A→0001000, b→0000011
  - c→0100111, d→0100001, E→0000110, F→0001110
  - Blank → 1111111.
- Leading-zero blanking applies when `lz_q`=1.
  - Digit k (k=5..1) is blank if nibbles k..5 are all zero.
  - HEX0 is never LZ-blanked, so value 0 shows a single "0".
- Blink:
  - A free-running counter runs 0..BLINK_DIV-1. At wrap it returns to 0 and toggles `phase`.
  - The counter is unaffected by writes.
  - When `phase`=1, every digit with `blink_q[k]`=1 is blank.
- Blanking priority: LZ blank or blink blank → 1111111; otherwise decode.

## Timing
- All outputs except `a_ready`/`b_ready` are registered.
- `hex*` are recomputed every cycle from the internal registers.
- Reset values (asynchronous, immediate):
  - `hex0`–`hex5` = 1111111
  - `grant_b`=0, `value_q`=0, `lz_q`=0, `blink_q`=0
  - `phase`=0, counter=0, `last_b`=1
  - state=IDLE
  - `a_ready`/`b_ready`=0 while `rst_n`=0.
- Write latency:
  - Transfer at edge N loads the registers.
  - `hex*` and `grant_b` reflect the new value after edge N+1.
  - The next possible transfer is edge N+2.
- Blink phase toggle:
  - The counter wraps at edge M; `hex*` reflect the new phase after edge M+1.
  - Phase toggles every BLINK_DIV cycles, starting BLINK_DIV cycles after reset release.
- Simultaneous events:
  - A write landing on the same edge as a phase toggle uses the new phase at the next edge.
  - A valid requester seen during UPDATE is served in the following IDLE cycle, with arbitration evaluated then.
- Reset mid-operation (including during UPDATE):
  - Aborts everything and blanks the displays.
  - A pending transfer on the reset edge is discarded.

## Test plan
- Reset and single write:
  - Release reset; check all `hex*`=1111111 and `grant_b`=0.
  - A writes 0x123456 with lz=0, blink=0. The ready pulse lasts 1 cycle. Two edges later, hex5..hex0 show 1,2,3,4,5,6 patterns.
- Leading-zero blanking:
  - A writes 0x00000A with lz=1 → hex5..hex1=1111111 and hex0=0001000.
  - Write 0x000000 with lz=1 → only hex0=1000000.
  - Write 0x050000 with lz=1 → hex5 blank; hex4..hex0 = 5,0,0,0,0.
- Contention round-robin:
  - Hold `a_valid` and `b_valid` high continuously with different values.
  - Grants are A,B,A,B on transfer cycles 0,2,4,6.
  - Ready is never high for both at once, and never high in UPDATE.
- Blink (BLINK_DIV=4):
  - Write 0xFFFFFF with blink=6'b000001.
  - hex0 alternates 0001110 / 1111111 every 4 cycles; hex1–hex5 stay steady at 0001110.
- Handshake hold and withdrawal:
  - Raise `b_valid` during UPDATE → `b_ready` appears in the next IDLE cycle.
  - Raise `a_valid` then drop it before ready → display unchanged.
- Async reset mid-update:
  - Assert `rst_n`=0 asynchronously in the UPDATE cycle.
  - Outputs blank immediately, with no clock edge required.
  - After release, the first contention grants A.
